// File: rtl/fpf_sched_pkg.sv
// Shared parameters, state encoding and helpers for the flattened-priority iSLIP scheduler.
package fpf_sched_pkg;

   localparam int unsigned N_DEF     = 24;
   localparam int unsigned P_DEF     = 8;
   localparam int unsigned LOG2N_DEF = $clog2(N_DEF);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } fpf_state_e;

   // Increment an index modulo n, so that n-1 wraps back to 0.
   function automatic logic [31:0] inc_mod_n(input logic [31:0] x, input int unsigned n);
      logic [31:0] nxt;
      nxt = x + 32'(1);
      return (nxt >= 32'(n)) ? 32'(0) : nxt;
   endfunction

endpackage : fpf_sched_pkg

// File: rtl/grant_arbiter_rr_select.sv
// Round-robin one-hot selector: first set mask bit at or after the pointer, wrapping.
module rr_select #(
   parameter int unsigned N     = 24,
   parameter int unsigned LOG2N = $clog2(N)
) (
   input  logic [N-1:0]     i_mask,
   input  logic [LOG2N-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic             o_any
);

   localparam int unsigned W2 = 2 * N;

   logic [W2-1:0] w_dbl;
   logic [W2-1:0] w_thermo;
   logic [W2-1:0] w_masked;
   logic [W2-1:0] w_iso;

   // Lower copy is gated by the pointer thermometer; the upper copy supplies the wrap-around.
   always_comb begin
      w_dbl    = {i_mask, i_mask};
      w_thermo = ~((W2'(1) << i_ptr) - W2'(1));
      w_masked = w_dbl & w_thermo;
      w_iso    = w_masked & (~w_masked + W2'(1));
      o_grant  = w_iso[N-1:0] | w_iso[W2-1:N];
      o_any    = |i_mask;
   end

endmodule : rr_select

// File: rtl/grant_arbiter.sv
// Output-side grant stage: highest priority level first, round-robin within that level.
module grant_arbiter
   import fpf_sched_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned P     = P_DEF,
   parameter int unsigned LOG2N = $clog2(N)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req_valid,
   input  logic [N-1:0]     i_request,
   input  logic [N*P-1:0]   i_priority,
   input  logic             i_first_iter,
   output logic             o_grant_valid,
   output logic [N-1:0]     o_grant,
   output logic [P-1:0]     o_grant_level,
   input  logic             i_accept_valid,
   input  logic             i_accept,
   output logic             o_busy
);

   localparam int unsigned LOG2P = (P > 1) ? $clog2(P) : 1;

   fpf_state_e                 r_state;
   logic                       r_grant_valid;
   logic [N-1:0]               r_grant;
   logic [P-1:0]               r_grant_level;
   logic [LOG2P-1:0]           r_level_idx;
   logic                       r_first;
   logic                       r_busy;
   logic [P-1:0][LOG2N-1:0]    r_ptr;

   logic [P-1:0][N-1:0]        w_elig;
   logic [LOG2P-1:0]           w_level_idx;
   logic [N-1:0]               w_sel_mask;
   logic [LOG2N-1:0]           w_sel_ptr;
   logic [N-1:0]               w_sel_grant;
   logic                       w_sel_any;
   logic [LOG2N-1:0]           w_gnt_idx;

   // Per-level eligibility; a multi-hot priority makes an input eligible at every set level.
   always_comb begin
      w_elig = '0;
      for (int l = 0; l < int'(P); l++) begin
         for (int i = 0; i < int'(N); i++) begin
            w_elig[l][i] = i_request[i] & i_priority[i*int'(P) + l];
         end
      end
   end

   // Highest level holding any eligible input; ascending scan so the top level wins.
   always_comb begin
      w_level_idx = '0;
      for (int l = 0; l < int'(P); l++) begin
         if (|w_elig[l]) begin
            w_level_idx = LOG2P'(l);
         end
      end
      w_sel_mask = w_elig[w_level_idx];
      w_sel_ptr  = r_ptr[w_level_idx];
   end

   rr_select #(
      .N     (N),
      .LOG2N (LOG2N)
   ) u_rr_select (
      .i_mask  (w_sel_mask),
      .i_ptr   (w_sel_ptr),
      .o_grant (w_sel_grant),
      .o_any   (w_sel_any)
   );

   // Binary index of the held grant, used to advance the level pointer.
   always_comb begin
      w_gnt_idx = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (r_grant[i]) begin
            w_gnt_idx = LOG2N'(i);
         end
      end
   end

   // Grant FSM: capture a grant in IDLE, hold it in WAIT until the accept stage answers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_grant_valid <= 1'b0;
         r_grant       <= '0;
         r_grant_level <= '0;
         r_level_idx   <= '0;
         r_first       <= 1'b0;
         r_busy        <= 1'b0;
         r_ptr         <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_req_valid && w_sel_any) begin
                  r_grant       <= w_sel_grant;
                  r_grant_level <= P'(1) << w_level_idx;
                  r_level_idx   <= w_level_idx;
                  r_first       <= i_first_iter;
                  r_grant_valid <= 1'b1;
                  r_busy        <= 1'b1;
                  r_state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_accept_valid) begin
                  if (i_accept && r_first) begin
                     r_ptr[r_level_idx] <= LOG2N'(inc_mod_n(32'(w_gnt_idx), N));
                  end
                  r_grant       <= '0;
                  r_grant_level <= '0;
                  r_grant_valid <= 1'b0;
                  r_busy        <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_grant_valid = r_grant_valid;
   assign o_grant       = r_grant;
   assign o_grant_level = r_grant_level;
   assign o_busy        = r_busy;

endmodule : grant_arbiter

// File: tb/tb_grant_arbiter.sv
// Self-checking bench for grant_arbiter against a scan-based reference model.
`timescale 1ns/1ps
module tb_grant_arbiter;
   import fpf_sched_pkg::*;

   localparam int N = 24;
   localparam int P = 8;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b1;
   logic           i_req_valid = 1'b0;
   logic [N-1:0]   i_request = '0;
   logic [N*P-1:0] i_priority = '0;
   logic           i_first_iter = 1'b0;
   logic           o_grant_valid;
   logic [N-1:0]   o_grant;
   logic [P-1:0]   o_grant_level;
   logic           i_accept_valid = 1'b0;
   logic           i_accept = 1'b0;
   logic           o_busy;

   int checks = 0;
   int errors = 0;
   int m_ptr [P];

   grant_arbiter #(.N(N), .P(P)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_req_valid    (i_req_valid),
      .i_request      (i_request),
      .i_priority     (i_priority),
      .i_first_iter   (i_first_iter),
      .o_grant_valid  (o_grant_valid),
      .o_grant        (o_grant),
      .o_grant_level  (o_grant_level),
      .i_accept_valid (i_accept_valid),
      .i_accept       (i_accept),
      .o_busy         (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Reference: walk levels top-down, and within a level walk inputs from the pointer.
   function automatic void model_pick(input logic [N-1:0] req, input logic [N*P-1:0] pr,
                                      output bit found, output int gi, output int gl);
      int idx;
      found = 0; gi = 0; gl = 0;
      for (int l = P - 1; l >= 0; l--) begin
         if (!found) begin
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr[l] + k) % N;
               if (!found && req[idx] && pr[idx*P + l]) begin
                  found = 1; gi = idx; gl = l;
               end
            end
         end
      end
   endfunction

   function automatic logic [N-1:0] onehot_n(input int i);
      logic [N-1:0] v;
      v = '0; v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [P-1:0] onehot_p(input int l);
      logic [P-1:0] v;
      v = '0; v[l] = 1'b1;
      return v;
   endfunction

   function automatic logic [N*P-1:0] set_prio(input logic [N*P-1:0] v, input int i, input int l);
      logic [N*P-1:0] r;
      r = v; r[i*P + l] = 1'b1;
      return r;
   endfunction

   task automatic send_req(input logic [N-1:0] req, input logic [N*P-1:0] pr, input bit first);
      i_req_valid = 1'b1; i_request = req; i_priority = pr; i_first_iter = first;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
   endtask

   task automatic send_acc(input bit acc, input bit with_req);
      i_accept_valid = 1'b1; i_accept = acc; i_req_valid = with_req;
      @(posedge i_clk); #1;
      i_accept_valid = 1'b0; i_req_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [N*P-1:0] pr;
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if ({o_grant_valid, o_grant, o_grant_level, o_busy} !== '0) begin
         errors++; $display("FAIL reset_outputs: got v=%b g=%h l=%h b=%b, want all zero",
                            o_grant_valid, o_grant, o_grant_level, o_busy);
      end
      i_rst = 1'b0;
      for (int i = 0; i < N; i++) pr = set_prio(i == 0 ? '0 : pr, i, i % P);
      for (int c = 0; c < 5; c++) begin
         send_req('0, pr, 1'b1);
         checks++;
         if (o_grant_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL no_request_cycle%0d: got v=%b b=%b, want 0 0", c, o_grant_valid, o_busy);
         end
      end
   endtask

   // Level 6 beats level 2 regardless of index order; accept advances only ptr[6].
   task automatic test_level_priority();
      logic [N*P-1:0] pr;
      pr = '0; pr = set_prio(pr, 3, 2); pr = set_prio(pr, 10, 2); pr = set_prio(pr, 5, 6);
      send_req(onehot_n(3) | onehot_n(10) | onehot_n(5), pr, 1'b1);
      checks++;
      if (o_grant_valid !== 1'b1 || o_grant !== onehot_n(5) || o_grant_level !== onehot_p(6) || o_busy !== 1'b1) begin
         errors++; $display("FAIL level_select: got v=%b g=%h l=%h, want 1 %h %h",
                            o_grant_valid, o_grant, o_grant_level, onehot_n(5), onehot_p(6));
      end
      send_acc(1'b1, 1'b0);
      m_ptr[6] = 6;
      checks++;
      if (o_grant_valid !== 1'b0 || o_busy !== 1'b0 || o_grant !== '0 || o_grant_level !== '0) begin
         errors++; $display("FAIL accept_to_idle: got v=%b b=%b g=%h", o_grant_valid, o_busy, o_grant);
      end
      // ptr[2] still 0: with 3 and 10 at level 2 the grant must go to 3.
      send_req(onehot_n(3) | onehot_n(10), set_prio(set_prio('0, 3, 2), 10, 2), 1'b1);
      checks++;
      if (o_grant !== onehot_n(3) || o_grant_level !== onehot_p(2)) begin
         errors++; $display("FAIL ptr2_untouched: got g=%h l=%h, want %h %h", o_grant, o_grant_level, onehot_n(3), onehot_p(2));
      end
      send_acc(1'b1, 1'b0);
      m_ptr[2] = 4;
   endtask

   // ptr[2]=4: grant 10, then ptr 11 wraps the scan back to 3.
   task automatic test_round_robin();
      logic [N*P-1:0] pr;
      pr = set_prio(set_prio('0, 3, 2), 10, 2);
      send_req(onehot_n(3) | onehot_n(10), pr, 1'b1);
      checks++;
      if (o_grant !== onehot_n(10)) begin
         errors++; $display("FAIL rr_after_ptr4: got %h, want %h", o_grant, onehot_n(10));
      end
      send_acc(1'b1, 1'b0);
      m_ptr[2] = 11;
      send_req(onehot_n(3) | onehot_n(10), pr, 1'b1);
      checks++;
      if (o_grant !== onehot_n(3)) begin
         errors++; $display("FAIL rr_wrap_scan: got %h, want %h", o_grant, onehot_n(3));
      end
      send_acc(1'b1, 1'b0);
      m_ptr[2] = 4;
   endtask

   // Accepting input 23 must wrap ptr[0] to 0, so input 0 wins next over 23.
   task automatic test_ptr_wrap();
      logic [N*P-1:0] pr;
      pr = set_prio(set_prio('0, 23, 0), 0, 0);
      send_req(onehot_n(23), pr, 1'b1);
      checks++;
      if (o_grant !== onehot_n(23) || o_grant_level !== onehot_p(0)) begin
         errors++; $display("FAIL grant_23: got g=%h l=%h, want %h %h", o_grant, o_grant_level, onehot_n(23), onehot_p(0));
      end
      send_acc(1'b1, 1'b0);
      m_ptr[0] = 0;
      send_req(onehot_n(23) | onehot_n(0), pr, 1'b1);
      checks++;
      if (o_grant !== onehot_n(0)) begin
         errors++; $display("FAIL ptr_wrap_to_0: got %h, want %h", o_grant, onehot_n(0));
      end
      send_acc(1'b1, 1'b0);
      m_ptr[0] = 1;
   endtask

   // Decline, or accept outside the first iteration, leaves the pointer alone.
   task automatic test_no_advance();
      logic [N*P-1:0] pr;
      pr = set_prio(set_prio('0, 3, 2), 10, 2);
      for (int r = 0; r < 3; r++) begin
         send_req(onehot_n(3) | onehot_n(10), pr, (r == 1) ? 1'b0 : 1'b1);
         checks++;
         if (o_grant !== onehot_n(10)) begin
            errors++; $display("FAIL no_advance_round%0d: got %h, want %h", r, o_grant, onehot_n(10));
         end
         send_acc((r == 0) ? 1'b0 : 1'b1, 1'b0);
      end
      m_ptr[2] = 11;
   endtask

   // Grant holds through new requests; accept with a request drops the request; reset clears all.
   task automatic test_hold_and_reset();
      logic [N*P-1:0] pr;
      pr = set_prio(set_prio('0, 3, 2), 10, 2);
      send_req(onehot_n(3) | onehot_n(10), pr, 1'b1);
      for (int c = 0; c < 4; c++) begin
         i_req_valid = 1'b1; i_request = N'($urandom) | onehot_n(7); i_priority = set_prio('0, 7, 7);
         @(posedge i_clk); #1;
         checks++;
         if (o_grant !== onehot_n(3) || o_grant_level !== onehot_p(2) || o_busy !== 1'b1) begin
            errors++; $display("FAIL hold_cycle%0d: got g=%h l=%h b=%b, want %h %h 1",
                               c, o_grant, o_grant_level, o_busy, onehot_n(3), onehot_p(2));
         end
      end
      send_acc(1'b1, 1'b1);
      m_ptr[2] = 4;
      @(posedge i_clk); #1;
      checks++;
      if (o_grant_valid !== 1'b0) begin
         errors++; $display("FAIL dropped_request: got v=%b, want 0", o_grant_valid);
      end
      send_acc(1'b1, 1'b0);
      send_req(onehot_n(3) | onehot_n(10), pr, 1'b1);
      checks++;
      if (o_grant !== onehot_n(10)) begin
         errors++; $display("FAIL idle_accept_ignored: got %h, want %h", o_grant, onehot_n(10));
      end
      i_rst = 1'b1;
      #1;
      checks++;
      if (o_grant_valid !== 1'b0 || o_busy !== 1'b0 || o_grant !== '0) begin
         errors++; $display("FAIL async_reset: got v=%b b=%b g=%h, want 0 0 0", o_grant_valid, o_busy, o_grant);
      end
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      for (int l = 0; l < P; l++) m_ptr[l] = 0;
      send_req(onehot_n(3) | onehot_n(10), pr, 1'b1);
      checks++;
      if (o_grant !== onehot_n(3)) begin
         errors++; $display("FAIL ptrs_cleared: got %h, want %h", o_grant, onehot_n(3));
      end
      send_acc(1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [N-1:0]   req, junk;
      logic [N*P-1:0] pr;
      bit found, first, acc;
      int gi, gl, lv;
      for (int it = 0; it < 300; it++) begin
         req = N'($urandom);
         if ($urandom_range(0, 2) == 0) req = req & N'($urandom) & N'($urandom);
         if ($urandom_range(0, 19) == 0) req = '0;
         pr = '0;
         for (int i = 0; i < N; i++) begin
            lv = $urandom_range(0, P - 1);
            pr = set_prio(pr, i, lv);
            if ($urandom_range(0, 7) == 0) pr = set_prio(pr, i, $urandom_range(0, P - 1));
         end
         first = ($urandom_range(0, 3) != 0);
         acc   = ($urandom_range(0, 3) != 0);
         model_pick(req, pr, found, gi, gl);
         send_req(req, pr, first);
         checks++;
         if (!found) begin
            if (o_grant_valid !== 1'b0) begin
               errors++; $display("FAIL rnd%0d_nogrant: got v=%b, want 0", it, o_grant_valid);
            end
            continue;
         end
         if (o_grant_valid !== 1'b1 || o_grant !== onehot_n(gi) || o_grant_level !== onehot_p(gl)) begin
            errors++; $display("FAIL rnd%0d_grant: got v=%b g=%h l=%h, want 1 %h %h",
                               it, o_grant_valid, o_grant, o_grant_level, onehot_n(gi), onehot_p(gl));
         end
         for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
            junk = N'($urandom);
            i_req_valid = $urandom_range(0, 1) == 1; i_request = junk;
            @(posedge i_clk); #1;
            i_req_valid = 1'b0;
            checks++;
            if (o_grant !== onehot_n(gi) || o_busy !== 1'b1) begin
               errors++; $display("FAIL rnd%0d_hold: got g=%h b=%b, want %h 1", it, o_grant, o_busy, onehot_n(gi));
            end
         end
         send_acc(acc, $urandom_range(0, 1) == 1);
         if (acc && first) m_ptr[gl] = (gi + 1) % N;
         if ($urandom_range(0, 4) == 0) send_acc(1'b1, 1'b0);
      end
   endtask

   initial begin
      for (int l = 0; l < P; l++) m_ptr[l] = 0;
      test_reset();
      test_level_priority();
      test_round_robin();
      test_ptr_wrap();
      test_no_advance();
      test_hold_and_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_grant_arbiter
